// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : ex_stage_pkg
// Brief  : Operation/result encodings and control constants for the EX stage.
// Rev    : 1.0  initial release
// ============================================================================
package ex_stage_pkg;

    localparam int c_ALU_OP_W  = 8;
    localparam int c_ALU_SEL_W = 3;

    localparam logic c_RST_ENABLE    = 1'b1;
    localparam logic c_STOP          = 1'b1;
    localparam logic c_NOT_STOP      = 1'b0;
    localparam logic c_WRITE_ENABLE  = 1'b1;
    localparam logic c_WRITE_DISABLE = 1'b0;

    typedef enum logic [c_ALU_OP_W-1:0] {
        EXE_NOP_OP   = 8'h00,
        EXE_AND_OP   = 8'h01,
        EXE_OR_OP    = 8'h02,
        EXE_XOR_OP   = 8'h03,
        EXE_NOR_OP   = 8'h04,
        EXE_SLL_OP   = 8'h05,
        EXE_SRL_OP   = 8'h06,
        EXE_SRA_OP   = 8'h07,
        EXE_ADDU_OP  = 8'h08,
        EXE_SUBU_OP  = 8'h09,
        EXE_SLT_OP   = 8'h0A,
        EXE_SLTU_OP  = 8'h0B,
        EXE_MFHI_OP  = 8'h0C,
        EXE_MFLO_OP  = 8'h0D,
        EXE_MTHI_OP  = 8'h0E,
        EXE_MTLO_OP  = 8'h0F,
        EXE_MULT_OP  = 8'h10,
        EXE_MULTU_OP = 8'h11,
        EXE_DIV_OP   = 8'h12,
        EXE_DIVU_OP  = 8'h13
    } alu_op_e;

    typedef enum logic [c_ALU_SEL_W-1:0] {
        EXE_RES_NOP   = 3'd0,
        EXE_RES_LOGIC = 3'd1,
        EXE_RES_SHIFT = 3'd2,
        EXE_RES_ARITH = 3'd3,
        EXE_RES_MOVE  = 3'd4
    } alu_sel_e;

    function automatic logic op_known(input alu_op_e op);
        return op inside {EXE_NOP_OP, EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP,
                          EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP, EXE_ADDU_OP, EXE_SUBU_OP,
                          EXE_SLT_OP, EXE_SLTU_OP, EXE_MFHI_OP, EXE_MFLO_OP, EXE_MTHI_OP,
                          EXE_MTLO_OP, EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP};
    endfunction

    function automatic logic sel_known(input alu_sel_e sel);
        return sel inside {EXE_RES_NOP, EXE_RES_LOGIC, EXE_RES_SHIFT, EXE_RES_ARITH, EXE_RES_MOVE};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_div_unit.sv
`default_nettype none
// ============================================================================
// Module : div_unit
// Brief  : Iterative radix-2 restoring divider, one quotient bit per cycle.
// Rev    : 1.0  initial release
// ============================================================================
module div_unit
    import ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div,
    input  logic [DATA_W-1:0]     op1,
    input  logic [DATA_W-1:0]     op2,
    input  logic                  start,
    input  logic                  annul,
    input  logic                  stall_hold,
    output logic [2*DATA_W-1:0]   result,
    output logic                  ready
);

    localparam int c_CNT_W = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    div_state_e          r_state_q, w_state_d;
    logic [c_CNT_W-1:0]  r_cnt_q,   w_cnt_d;
    logic [DATA_W-1:0]   r_quo_q,   w_quo_d;
    logic [DATA_W-1:0]   r_rem_q,   w_rem_d;
    logic [DATA_W-1:0]   r_dvs_q,   w_dvs_d;
    logic                r_neg_quo_q, w_neg_quo_d;
    logic                r_neg_rem_q, w_neg_rem_d;

    logic [DATA_W:0]     w_shift_rem;
    logic [DATA_W:0]     w_trial;

    // Quotient register doubles as the dividend shift register.
    assign w_shift_rem = {r_rem_q, r_quo_q[DATA_W-1]};
    assign w_trial     = w_shift_rem - {1'b0, r_dvs_q};

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_quo_d     = r_quo_q;
        w_rem_d     = r_rem_q;
        w_dvs_d     = r_dvs_q;
        w_neg_quo_d = r_neg_quo_q;
        w_neg_rem_d = r_neg_rem_q;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    if (op2 == '0) begin
                        w_quo_d     = '0;
                        w_rem_d     = '0;
                        w_neg_quo_d = 1'b0;
                        w_neg_rem_d = 1'b0;
                        w_state_d   = S_DONE;
                    end else begin
                        w_quo_d     = (signed_div && op1[DATA_W-1]) ? -op1 : op1;
                        w_dvs_d     = (signed_div && op2[DATA_W-1]) ? -op2 : op2;
                        w_rem_d     = '0;
                        w_cnt_d     = '0;
                        w_neg_quo_d = signed_div && (op1[DATA_W-1] ^ op2[DATA_W-1]);
                        w_neg_rem_d = signed_div && op1[DATA_W-1];
                        w_state_d   = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (annul) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_rem_d = w_trial[DATA_W] ? w_shift_rem[DATA_W-1:0] : w_trial[DATA_W-1:0];
                    w_quo_d = {r_quo_q[DATA_W-2:0], ~w_trial[DATA_W]};
                    w_cnt_d = r_cnt_q + c_CNT_W'(1);
                    if (r_cnt_q == c_CNT_W'(DIV_CYCLES - 1)) begin
                        w_state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!stall_hold) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == c_RST_ENABLE) begin
            r_state_q   <= S_IDLE;
            r_cnt_q     <= '0;
            r_quo_q     <= '0;
            r_rem_q     <= '0;
            r_dvs_q     <= '0;
            r_neg_quo_q <= 1'b0;
            r_neg_rem_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_quo_q     <= w_quo_d;
            r_rem_q     <= w_rem_d;
            r_dvs_q     <= w_dvs_d;
            r_neg_quo_q <= w_neg_quo_d;
            r_neg_rem_q <= w_neg_rem_d;
        end
    end

    assign ready  = (r_state_q == S_DONE);
    assign result = {(r_neg_rem_q ? -r_rem_q : r_rem_q),
                     (r_neg_quo_q ? -r_quo_q : r_quo_q)};

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module : ex_stage
// Brief  : Execute stage: combinational ALU/multiplier, iterative divider, result mux.
// Rev    : 1.0  initial release
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [c_ALU_OP_W-1:0]   alu_op,
    input  logic [c_ALU_SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0]       reg_data_1,
    input  logic [DATA_W-1:0]       reg_data_2,
    input  logic [4:0]              reg_write_addr,
    input  logic                    reg_write_en,
    input  logic [DATA_W-1:0]       hi_i,
    input  logic [DATA_W-1:0]       lo_i,
    input  logic [5:0]              stall,
    output logic [DATA_W-1:0]       wb_reg_write_data,
    output logic [4:0]              wb_reg_write_addr,
    output logic                    wb_reg_write_en,
    output logic                    hilo_write_en,
    output logic [DATA_W-1:0]       hi_o,
    output logic [DATA_W-1:0]       lo_o,
    output logic                    stallreq
);

    localparam int c_SHAMT_W = $clog2(DATA_W);

    alu_op_e                w_op;
    alu_sel_e               w_sel;
    logic                   w_is_div;
    logic                   w_is_signed;
    logic [c_SHAMT_W-1:0]   w_shamt;
    logic [DATA_W-1:0]      w_logic, w_shift, w_arith, w_move;
    logic [DATA_W-1:0]      w_mag1, w_mag2;
    logic [2*DATA_W-1:0]    w_umul, w_prod;
    logic [2*DATA_W-1:0]    w_div_result;
    logic                   w_div_ready;
    logic                   w_unused;

    assign w_op        = alu_op_e'(alu_op);
    assign w_sel       = alu_sel_e'(alu_sel);
    assign w_is_div    = (w_op == EXE_DIV_OP) || (w_op == EXE_DIVU_OP);
    assign w_is_signed = (w_op == EXE_MULT_OP) || (w_op == EXE_DIV_OP);
    assign w_shamt     = reg_data_1[c_SHAMT_W-1:0];
    assign w_unused    = ^{stall[5:4], stall[2:0]};

    always_comb begin
        w_logic = '0;
        w_shift = '0;
        w_arith = '0;
        w_move  = '0;
        case (w_op)
            EXE_AND_OP:  w_logic = reg_data_1 & reg_data_2;
            EXE_OR_OP:   w_logic = reg_data_1 | reg_data_2;
            EXE_XOR_OP:  w_logic = reg_data_1 ^ reg_data_2;
            EXE_NOR_OP:  w_logic = ~(reg_data_1 | reg_data_2);
            EXE_SLL_OP:  w_shift = reg_data_2 << w_shamt;
            EXE_SRL_OP:  w_shift = reg_data_2 >> w_shamt;
            EXE_SRA_OP:  w_shift = $unsigned($signed(reg_data_2) >>> w_shamt);
            EXE_ADDU_OP: w_arith = reg_data_1 + reg_data_2;
            EXE_SUBU_OP: w_arith = reg_data_1 - reg_data_2;
            EXE_SLT_OP:  w_arith = {{(DATA_W-1){1'b0}}, ($signed(reg_data_1) < $signed(reg_data_2))};
            EXE_SLTU_OP: w_arith = {{(DATA_W-1){1'b0}}, (reg_data_1 < reg_data_2)};
            EXE_MFHI_OP: w_move  = hi_i;
            EXE_MFLO_OP: w_move  = lo_i;
            default: ;
        endcase
    end

    // Signed multiply runs on magnitudes; the sign is restored on the full product.
    assign w_mag1 = (w_is_signed && reg_data_1[DATA_W-1]) ? -reg_data_1 : reg_data_1;
    assign w_mag2 = (w_is_signed && reg_data_2[DATA_W-1]) ? -reg_data_2 : reg_data_2;
    assign w_umul = {{DATA_W{1'b0}}, w_mag1} * {{DATA_W{1'b0}}, w_mag2};
    assign w_prod = (w_is_signed && (reg_data_1[DATA_W-1] ^ reg_data_2[DATA_W-1])) ? -w_umul : w_umul;

    div_unit #(
        .DATA_W     (DATA_W),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_unit (
        .clk        (clk),
        .rst        (rst),
        .signed_div (w_op == EXE_DIV_OP),
        .op1        (reg_data_1),
        .op2        (reg_data_2),
        .start      (w_is_div),
        .annul      (!w_is_div),
        .stall_hold (stall[3] == c_STOP),
        .result     (w_div_result),
        .ready      (w_div_ready)
    );

    assign stallreq = w_is_div && !w_div_ready;

    always_comb begin
        wb_reg_write_data = '0;
        case (w_sel)
            EXE_RES_LOGIC: wb_reg_write_data = w_logic;
            EXE_RES_SHIFT: wb_reg_write_data = w_shift;
            EXE_RES_ARITH: wb_reg_write_data = w_arith;
            EXE_RES_MOVE:  wb_reg_write_data = w_move;
            default: ;
        endcase
        wb_reg_write_addr = reg_write_addr;
        wb_reg_write_en   = (reg_write_en && op_known(w_op) && sel_known(w_sel) && !stallreq)
                            ? c_WRITE_ENABLE : c_WRITE_DISABLE;

        hilo_write_en = c_WRITE_DISABLE;
        hi_o          = '0;
        lo_o          = '0;
        case (w_op)
            EXE_MULT_OP, EXE_MULTU_OP: begin
                hilo_write_en = c_WRITE_ENABLE;
                {hi_o, lo_o}  = w_prod;
            end
            EXE_DIV_OP, EXE_DIVU_OP: begin
                if (w_div_ready) begin
                    hilo_write_en = c_WRITE_ENABLE;
                    {hi_o, lo_o}  = w_div_result;
                end
            end
            EXE_MTHI_OP: begin
                hilo_write_en = c_WRITE_ENABLE;
                hi_o          = reg_data_1;
                lo_o          = lo_i;
            end
            EXE_MTLO_OP: begin
                hilo_write_en = c_WRITE_ENABLE;
                hi_o          = hi_i;
                lo_o          = reg_data_1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
